ro_cnt_ctrl: RTL and testbench

Measurement-window controller for one ring-oscillator pair in the RO PUF. It sits between the PUF sequencer and the RO edge synchronizers. While `roen` is high it runs a settle period and then a fixed counting window, and counts synchronized edge ticks from RO A and RO B. It then publishes a one-bit response and reports completion through `counter_ctrl_state`. The sequencer treats `counter_ctrl_state == 2'b11` as "response bit ready", shifts the bit into the signature register and drops `roen`.

---
 rtl/ro_cnt_ctrl.sv | 112 +++++++++++
 tb/tb_ro_cnt_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ro_cnt_ctrl.sv
// Measurement-window controller for one ring-oscillator pair of the RO PUF.
// While roen is held high it runs a settle period and then a fixed counting
// window. During the window it counts synchronized edge ticks from RO A and
// RO B. On the edge that enters DONE it publishes a one-bit response and a
// tie flag. counter_ctrl_state == 2'b11 tells the sequencer the bit is ready.
module ro_cnt_ctrl #(
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             roen,
  input  logic             ro_a_tick,
  input  logic             ro_b_tick,
  output logic [1:0]       counter_ctrl_state,
  output logic             resp_bit,
  output logic             resp_tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_COUNT  = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // Terminal values of the shared settle/window counter (it counts from 0).
  localparam logic [15:0] SET_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  state_t           state;
  logic [15:0]      tcnt;
  logic [CNT_W-1:0] cnt_a_nxt;
  logic [CNT_W-1:0] cnt_b_nxt;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) r = v + 1'b1;
    return r;
  endfunction

  // Counts as they will stand after this cycle if the tick is accepted; the
  // response compare uses these so a tick in the last window cycle is included.
  always_comb begin
    cnt_a_nxt = sat_inc(cnt_a, ro_a_tick);
    cnt_b_nxt = sat_inc(cnt_b, ro_b_tick);
  end

  assign counter_ctrl_state = state;

  // Measurement FSM with registered counts and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      resp_bit <= 1'b0;
      resp_tie <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (roen) begin
            state <= S_SETTLE;
            tcnt  <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
          end
        end
        S_SETTLE: begin
          // Ticks are ignored here so the oscillators can stabilise.
          if (!roen) begin
            state <= S_IDLE;
          end else if (tcnt == SET_LAST) begin
            state <= S_COUNT;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_COUNT: begin
          // An abort freezes the counts as they were; no compare is made.
          if (!roen) begin
            state <= S_IDLE;
          end else begin
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
            if (tcnt == WIN_LAST) begin
              state    <= S_DONE;
              tcnt     <= '0;
              resp_bit <= (cnt_a_nxt > cnt_b_nxt);
              resp_tie <= (cnt_a_nxt == cnt_b_nxt);
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
        end
        S_DONE: begin
          if (!roen) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_cnt_ctrl.sv
// Bench for ro_cnt_ctrl: a WINDOW=16/SETTLE=4 instance for the table of
// measurements and the abort/reset sequences, and a CNT_W=4/WINDOW=40
// instance for counter saturation.
module tb_ro_cnt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 1: WINDOW=16, SETTLE=4, CNT_W=16
  logic        rst, roen, ta, tb_t;
  logic [1:0]  st;
  logic        rb, rt;
  logic [15:0] ca, cb;

  ro_cnt_ctrl #(.WINDOW(16), .SETTLE(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .roen(roen), .ro_a_tick(ta), .ro_b_tick(tb_t),
    .counter_ctrl_state(st), .resp_bit(rb), .resp_tie(rt),
    .cnt_a(ca), .cnt_b(cb)
  );

  // Instance 2: WINDOW=40, SETTLE=4, CNT_W=4
  logic        roen2, ta2, tb2;
  logic [1:0]  st2;
  logic        rb2, rt2;
  logic [3:0]  ca2, cb2;

  ro_cnt_ctrl #(.WINDOW(40), .SETTLE(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .roen(roen2), .ro_a_tick(ta2), .ro_b_tick(tb2),
    .counter_ctrl_state(st2), .resp_bit(rb2), .resp_tie(rt2),
    .cnt_a(ca2), .cnt_b(cb2)
  );

  typedef struct {
    logic [15:0] am;    // bit i: RO A tick in COUNT cycle i
    logic [15:0] bm;    // bit i: RO B tick in COUNT cycle i
    logic        stk;   // also tick both ROs during roen rise and SETTLE
    int          ea;
    int          eb;
    logic        erb;
    logic        ert;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{am:16'hFFFF, bm:16'h5555, stk:1'b1, ea:16, eb:8,  erb:1'b1, ert:1'b0};
    vecs[1] = '{am:16'h9111, bm:16'h01FF, stk:1'b0, ea:5,  eb:9,  erb:1'b0, ert:1'b0};
    vecs[2] = '{am:16'h803F, bm:16'hC01F, stk:1'b1, ea:7,  eb:7,  erb:1'b0, ert:1'b1};
    vecs[3] = '{am:16'h0000, bm:16'h0000, stk:1'b0, ea:0,  eb:0,  erb:1'b0, ert:1'b1};
    vecs[4] = '{am:16'hFFFF, bm:16'hFFFE, stk:1'b0, ea:16, eb:15, erb:1'b1, ert:1'b0};

    rst = 1'b1; roen = 1'b0; ta = 1'b0; tb_t = 1'b0;
    roen2 = 1'b0; ta2 = 1'b0; tb2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 32'(st), 32'd0);
    check("rst_resp_bit", 32'(rb), 32'd0);
    check("rst_resp_tie", 32'(rt), 32'd0);
    check("rst_cnt_a", 32'(ca), 32'd0);
    check("rst_cnt_b", 32'(cb), 32'd0);
    check("rst_state2", 32'(st2), 32'd0);
    tick();

    // Back-to-back measurements from the table, each with a DONE handshake.
    for (int v = 0; v < 5; v++) begin
      roen = 1'b1;                       // cycle n
      ta = vecs[v].stk; tb_t = vecs[v].stk;
      tick();
      check("settle_state", 32'(st), 32'd1);
      for (int s = 0; s < 4; s++) begin
        check("settle_cnt_a", 32'(ca), 32'd0);
        tick();
      end
      check("count_state", 32'(st), 32'd2);
      for (int i = 0; i < 16; i++) begin
        ta = vecs[v].am[i]; tb_t = vecs[v].bm[i];
        if (i < 15) check("count_hold", 32'(st), 32'd2);
        tick();
      end
      ta = 1'b1; tb_t = 1'b0;            // ticks in DONE must be ignored
      check("done_state", 32'(st), 32'd3);
      check("done_cnt_a", 32'(ca), 32'(vecs[v].ea));
      check("done_cnt_b", 32'(cb), 32'(vecs[v].eb));
      check("done_resp_bit", 32'(rb), 32'(vecs[v].erb));
      check("done_resp_tie", 32'(rt), 32'(vecs[v].ert));
      for (int h = 0; h < 3; h++) begin
        tick();
        check("done_hold_state", 32'(st), 32'd3);
        check("done_hold_cnt_a", 32'(ca), 32'(vecs[v].ea));
      end
      roen = 1'b0; ta = 1'b0; tb_t = 1'b0;
      tick();
      check("release_state", 32'(st), 32'd0);
      check("release_resp_bit", 32'(rb), 32'(vecs[v].erb));
      check("release_cnt_b", 32'(cb), 32'(vecs[v].eb));
    end

    // Abort at COUNT cycle 5 after a measurement left resp_bit = 1.
    roen = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) tick();
    check("abort_pre_state", 32'(st), 32'd2);
    for (int i = 0; i < 5; i++) begin
      ta = 1'b1; tb_t = 1'b0;
      tick();
    end
    roen = 1'b0; ta = 1'b0;
    tick();
    check("abort_state", 32'(st), 32'd0);
    check("abort_resp_bit", 32'(rb), 32'd1);
    check("abort_resp_tie", 32'(rt), 32'd0);
    check("abort_cnt_a", 32'(ca), 32'd5);
    tick();
    check("abort_idle_hold", 32'(st), 32'd0);
    roen = 1'b1;
    tick();
    check("restart_state", 32'(st), 32'd1);
    check("restart_cnt_a", 32'(ca), 32'd0);
    check("restart_resp_bit", 32'(rb), 32'd1);
    roen = 1'b0;
    tick();
    check("restart_abort_state", 32'(st), 32'd0);
    tick();

    // Synchronous reset at COUNT cycle 8: everything clears, no DONE.
    roen = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) tick();
    for (int i = 0; i < 8; i++) begin
      ta = 1'b1; tb_t = 1'b1;
      tick();
    end
    check("prerst_cnt_a", 32'(ca), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0; roen = 1'b0; ta = 1'b0; tb_t = 1'b0;
    check("midrst_state", 32'(st), 32'd0);
    check("midrst_cnt_a", 32'(ca), 32'd0);
    check("midrst_cnt_b", 32'(cb), 32'd0);
    check("midrst_resp_bit", 32'(rb), 32'd0);
    check("midrst_resp_tie", 32'(rt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("midrst_no_done", 32'(st), 32'd0);
    end

    // Saturation on the 4-bit instance: A every cycle, B in 20 cycles.
    roen2 = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) tick();
    check("sat_count_state", 32'(st2), 32'd2);
    for (int i = 0; i < 40; i++) begin
      ta2 = 1'b1; tb2 = (i < 20);
      tick();
    end
    ta2 = 1'b0; tb2 = 1'b0;
    check("sat_state", 32'(st2), 32'd3);
    check("sat_cnt_a", 32'(ca2), 32'd15);
    check("sat_cnt_b", 32'(cb2), 32'd15);
    check("sat_resp_tie", 32'(rt2), 32'd1);
    check("sat_resp_bit", 32'(rb2), 32'd0);
    roen2 = 1'b0;
    tick();
    check("sat_release", 32'(st2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
